// File: rtl/raiz_pkg.sv
// Shared types and helpers for the raiz square-root arbiter family.
// RAIZ_OP_SLICE picks requester idx's w-bit field out of a flattened operand bus.
`ifndef RAIZ_OP_SLICE
`define RAIZ_OP_SLICE(bus, idx, w) bus[int'(idx)*(w) +: (w)]
`endif

package raiz_pkg;

  localparam int RAIZ_DW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping at NREQ-1.
// Zero latency; no flow control of its own, the caller decides when a pick is consumed.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < NREQ; i++) begin
      // explicit wrap so non-power-of-two NREQ never lands on a missing requester
      pos = {1'b0, ptr} + (IW + 1)'(i);
      if (pos > (IW + 1)'(NREQ - 1)) pos = pos - (IW + 1)'(NREQ);
      if (!any && req[pos[IW-1:0]]) begin
        any              = 1'b1;
        gnt[pos[IW-1:0]] = 1'b1;
        idx              = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/raiz_arbiter.sv
// Round-robin share of one raiz_16 core; ack and core_init pulse together, result strobes once per grant.
// Optional RAIZ_ARB_TIMEOUT_EN adds a WAIT watchdog that returns res_err with zero results.
module raiz_arbiter
  import raiz_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = RAIZ_DW,
  parameter int DONE_MASK = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] operand,
  output logic [NREQ-1:0]   ack,
  output logic              res_valid,
  output logic [2:0]        res_id,
  output logic [DW-1:0]     res_q,
  output logic [DW-1:0]     res_r,
  output logic              res_err,
  output logic              busy,
  output logic              core_init,
  output logic [DW-1:0]     core_in,
  input  logic              core_done,
  input  logic [DW-1:0]     core_q,
  input  logic [DW-1:0]     core_r
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WMAX = (TIMEOUT > DONE_MASK) ? TIMEOUT : DONE_MASK;
  localparam int CW   = $clog2(WMAX + 2);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [CW-1:0]   wait_cnt;
  logic            done_ok;
  logic            timed_out;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // wait_cnt counts WAIT cycles; the first DONE_MASK of them carry the previous op's stale done
  assign done_ok = (wait_cnt >= CW'(DONE_MASK)) && core_done;
  assign busy    = (state != S_IDLE);

`ifdef RAIZ_ARB_TIMEOUT_EN
  logic err_q;
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  assign res_err   = err_q;
`else
  assign timed_out = 1'b0;
  assign res_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gid       <= '0;
      ack       <= '0;
      core_init <= 1'b0;
      core_in   <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_q     <= '0;
      res_r     <= '0;
      wait_cnt  <= '0;
`ifdef RAIZ_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ack       <= '0;
      core_init <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            ack       <= pick_gnt;
            gid       <= pick_idx;
            core_in   <= `RAIZ_OP_SLICE(operand, pick_idx, DW);
            core_init <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (done_ok) begin
            res_q     <= core_q;
            res_r     <= core_r;
            res_id    <= 3'(gid);
            res_valid <= 1'b1;
`ifdef RAIZ_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= S_RESP;
          end else if (timed_out) begin
            res_q     <= '0;
            res_r     <= '0;
            res_id    <= 3'(gid);
            res_valid <= 1'b1;
`ifdef RAIZ_ARB_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
            state     <= S_RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESP: begin
          ptr   <= (gid == IW'(NREQ - 1)) ? '0 : gid + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_arbiter.sv
// Directed bench for raiz_arbiter with a behavioural square-root core on the core_* side.
`timescale 1ns/1ps
module tb_raiz_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 16;
  localparam int DONE_MASK = 2;
  localparam int TIMEOUT   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   operand = '0;
  logic [NREQ-1:0]      ack;
  logic                 res_valid, res_err, busy, core_init, core_done;
  logic [2:0]           res_id;
  logic [DW-1:0]        res_q, res_r, core_in, core_q, core_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  raiz_arbiter #(.NREQ(NREQ), .DW(DW), .DONE_MASK(DONE_MASK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .operand(operand), .ack(ack),
    .res_valid(res_valid), .res_id(res_id), .res_q(res_q), .res_r(res_r), .res_err(res_err),
    .busy(busy), .core_init(core_init), .core_in(core_in),
    .core_done(core_done), .core_q(core_q), .core_r(core_r)
  );

  // Behavioural core: result and done appear core_lat cycles after init; optional stale done.
  int            core_lat = 5;
  bit            stale_en = 1'b0;
  bit            never    = 1'b0;
  int            k        = 0;
  bit            run      = 1'b0;
  bit            stale    = 1'b0;
  logic [DW-1:0] nq = '0, nr = '0;

  function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] x);
    int unsigned q = 0;
    while ((q + 1) * (q + 1) <= x) q++;
    return DW'(q);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      run <= 1'b0; k <= 0; stale <= 1'b0;
    end else if (core_init) begin
      run   <= 1'b1;
      k     <= 1;
      stale <= stale_en && core_done;
      nq    <= isqrt(core_in);
      nr    <= core_in - isqrt(core_in) * isqrt(core_in);
    end else if (run && k < 1000) begin
      k <= k + 1;
    end
  end

  assign core_done = run && !never && ((k >= core_lat) || (stale && k <= 2));
  assign core_q    = (run && !never && k >= core_lat) ? nq : 16'hDEAD;
  assign core_r    = (run && !never && k >= core_lat) ? nr : 16'hBEEF;

  task automatic do_reset;
    rst = 1'b1; req = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    checks++; if (ack !== '0)       begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (core_init !== 1'b0) begin errors++; $display("FAIL reset_core_init got %b want 0", core_init); end
    checks++; if (core_in !== '0)   begin errors++; $display("FAIL reset_core_in got %0d want 0", core_in); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %b want 0", res_err); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int n; int inits;
    do_reset();
    operand[0*DW +: DW] = 16'd144;
    req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 20);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
    req = '0;
    inits = (core_init === 1'b1) ? 1 : 0;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (core_init === 1'b1) inits++;
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_wait got none want res_valid"); end
    checks++; if (inits != 1)       begin errors++; $display("FAIL single_init_pulses got %0d want 1", inits); end
    checks++; if (res_id !== 3'd0)  begin errors++; $display("FAIL single_res_id got %0d want 0", res_id); end
    checks++; if (res_q !== 16'd12) begin errors++; $display("FAIL single_res_q got %0d want 12", res_q); end
    checks++; if (res_r !== 16'd0)  begin errors++; $display("FAIL single_res_r got %0d want 0", res_r); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL single_res_err got %b want 0", res_err); end
    checks++; if (core_in !== 16'd144) begin errors++; $display("FAIL single_core_in_hold got %0d want 144", core_in); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_simul;
    int n;
    int eq[4] = '{14, 9, 255, 1};
    int er[4] = '{4, 0, 510, 1};
    logic [NREQ-1:0] exp_ack;
    do_reset();
    operand[0*DW +: DW] = 16'd200;
    operand[1*DW +: DW] = 16'd81;
    operand[2*DW +: DW] = 16'd65535;
    operand[3*DW +: DW] = 16'd2;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp_ack = '0; exp_ack[g] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL simul_ack%0d got %b want %b", g, ack, exp_ack); end
      req = req & ~ack;
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (res_id !== 3'(g)) begin errors++; $display("FAIL simul_id%0d got %0d want %0d", g, res_id, g); end
      checks++; if (res_q !== DW'(eq[g])) begin errors++; $display("FAIL simul_q%0d got %0d want %0d", g, res_q, eq[g]); end
      checks++; if (res_r !== DW'(er[g])) begin errors++; $display("FAIL simul_r%0d got %0d want %0d", g, res_r, er[g]); end
    end
  endtask

  task automatic test_fairness;
    int n;
    int seq[6] = '{0, 2, 0, 2, 0, 1};
    logic [NREQ-1:0] exp_ack;
    do_reset();
    operand[0*DW +: DW] = 16'd25;
    operand[1*DW +: DW] = 16'd49;
    operand[2*DW +: DW] = 16'd36;
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      exp_ack = '0; exp_ack[seq[i]] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL fair_grant%0d got %b want %b", i, ack, exp_ack); end
      if (i == 3) req[1] = 1'b1;
      if (i == 5) req = '0;
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (res_id !== 3'(seq[i])) begin errors++; $display("FAIL fair_id%0d got %0d want %0d", i, res_id, seq[i]); end
    end
    checks++; if (res_q !== 16'd7) begin errors++; $display("FAIL fair_late_q got %0d want 7", res_q); end
  endtask

  task automatic test_stale;
    int n;
    do_reset();
    stale_en = 1'b1;
    operand[0*DW +: DW] = 16'd144;
    operand[3*DW +: DW] = 16'd100;
    req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    req = '0;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    req = 4'b1000;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL stale_ack got %b want 1000", ack); end
    req = '0;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n <= core_lat) begin errors++; $display("FAIL stale_early got %0d cycles want more than %0d", n, core_lat); end
    checks++; if (res_q !== 16'd10) begin errors++; $display("FAIL stale_q got %0d want 10", res_q); end
    checks++; if (res_r !== 16'd0)  begin errors++; $display("FAIL stale_r got %0d want 0", res_r); end
    stale_en = 1'b0;
  endtask

  task automatic test_midreset;
    int n; int seen;
    do_reset();
    operand[0*DW +: DW] = 16'd144;
    operand[1*DW +: DW] = 16'd49;
    req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    req = '0;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    req = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (ack !== '0)    begin errors++; $display("FAIL midrst_ack got %b want 0", ack); end
    checks++; if (core_init !== 1'b0) begin errors++; $display("FAIL midrst_init got %b want 0", core_init); end
    rst = 1'b0;
    seen = (res_valid === 1'b1) ? 1 : 0;
    repeat (12) begin @(negedge clk); if (res_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_result got %0d strobes want 0", seen); end
    req = 4'b0011;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got %b want 0001", ack); end
    req = 4'b0010;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (res_q !== 16'd12) begin errors++; $display("FAIL midrst_after_q got %0d want 12", res_q); end
    req = '0;
  endtask

`ifdef RAIZ_ARB_TIMEOUT_EN
  task automatic test_watchdog;
    int n;
    do_reset();
    never = 1'b1;
    operand[0*DW +: DW] = 16'd64;
    operand[1*DW +: DW] = 16'd16;
    req = 4'b0011;
    n = 0;
    do begin @(negedge clk); n++; end while (core_init !== 1'b1 && n < 40);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wd_ack0 got %b want 0001", ack); end
    req = 4'b0010;
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL wd_latency got %0d want %0d", n, TIMEOUT + 1); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL wd_err got %b want 1", res_err); end
    checks++; if (res_q !== '0 || res_r !== '0) begin errors++; $display("FAIL wd_zero got q=%0d r=%0d want 0 0", res_q, res_r); end
    never = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack === '0 && n < 40);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL wd_next got %b want 0010", ack); end
    req = '0;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (res_q !== 16'd4 || res_err !== 1'b0) begin errors++; $display("FAIL wd_recover got q=%0d err=%b want 4 0", res_q, res_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_fairness();
    test_stale();
    test_midreset();
`ifdef RAIZ_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
